swim_rx: RTL and testbench

SWIM_RX -- requirements
Module: swim_rx

---
 rtl/swim_rx_if.sv | 22 ++
 rtl/swim_rx.sv | 185 ++++++++++++++++++
 tb/tb_swim_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/swim_rx_if.sv
// Byte handshake between the SWIM receiver and its consumer.
// The receiver holds a byte until the consumer accepts it.
interface swim_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        output rx_ready
    );
endinterface

// File: rtl/swim_rx.sv
// SWIM single-wire receiver: times the low phases of a synchronized pad input.
// Each frame is a start bit, 8 data bits (MSB first) and a parity bit.
module swim_rx #(
    parameter int unsigned THRESHOLD = 66,
    parameter int unsigned MIN_LOW   = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          swim_in,
    swim_rx_if.master     rx_bus,
    output logic          rx_overflow,
    output logic          frame_err,
    output logic          busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;

    localparam logic [11:0] TimeoutCnt = 12'(TIMEOUT);
    localparam logic [12:0] ThreshLen  = 13'(THRESHOLD);
    localparam logic [12:0] MinLowLen  = 13'(MIN_LOW);

    logic        sync1_q, sync2_q, prev_q;
    logic        fall, rise;
    logic [1:0]  state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ovf_q, ovf_d;
    logic        ferr_q, ferr_d;
    logic [12:0] low_len;
    logic        bit_val, glitch;
    logic        done, done_perr, xfer;

    // Synchronizer idles high so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= swim_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;
    assign rise = ~prev_q & sync2_q;

    // The counter reads N-1 on the rise ending an N-cycle low phase.
    assign low_len = {1'b0, cnt_q} + 13'd1;
    assign bit_val = (low_len < ThreshLen);
    assign glitch  = (low_len < MinLowLen);
    assign xfer    = valid_q & rx_bus.rx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        done      = 1'b0;
        done_perr = 1'b0;

        if (state_q == StIdle || fall || rise) begin
            cnt_d = 12'd0;
        end else if (cnt_q != 12'hfff) begin
            cnt_d = cnt_q + 12'd1;
        end

        case (state_q)
            StIdle: begin
                bit_cnt_d = 4'd0;
                if (en && fall) state_d = StLow;
            end
            StLow: begin
                if (cnt_q == TimeoutCnt) begin
                    ferr_d    = 1'b1;
                    state_d   = StIdle;
                    bit_cnt_d = 4'd0;
                end else if (rise) begin
                    if (glitch) begin
                        state_d = (bit_cnt_q == 4'd0) ? StIdle : StHigh;
                    end else if (bit_cnt_q == 4'd0) begin
                        // A start bit decoding as '1' is not a frame.
                        if (bit_val) begin
                            state_d = StIdle;
                        end else begin
                            bit_cnt_d = 4'd1;
                            state_d   = StHigh;
                        end
                    end else if (bit_cnt_q == 4'd9) begin
                        done      = 1'b1;
                        done_perr = bit_val ^ (^shift_q);
                        bit_cnt_d = 4'd0;
                        state_d   = StIdle;
                    end else begin
                        shift_d   = {shift_q[6:0], bit_val};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = StHigh;
                    end
                end
            end
            StHigh: begin
                if (bit_cnt_q != 4'd0 && cnt_q == TimeoutCnt) begin
                    ferr_d    = 1'b1;
                    state_d   = StIdle;
                    bit_cnt_d = 4'd0;
                end else if (fall) begin
                    state_d = StLow;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = 4'd0;
            end
        endcase

        if (!en) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            cnt_d     = 12'd0;
            ferr_d    = 1'b0;
            done      = 1'b0;
        end
    end

    // Output holding register runs regardless of en so the consumer can drain.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovf_d   = 1'b0;
        if (done) begin
            if (!valid_q || xfer) begin
                data_d  = shift_q;
                perr_d  = done_perr;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 12'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_bus.rx_data       = data_q;
    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.rx_parity_err = perr_q;
    assign rx_overflow          = ovf_q;
    assign frame_err            = ferr_q;
    assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_swim_rx.sv
// Bench for swim_rx: directed scenarios plus randomized frames, checked against
// a queue of bytes the sender intends to deliver.
module tb_swim_rx;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic swim_in = 1'b1;
    logic rx_overflow, frame_err, busy;

    swim_rx_if bus ();

    swim_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .swim_in     (swim_in),
        .rx_bus      (bus),
        .rx_overflow (rx_overflow),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    int ferr_cnt = 0;
    int xfer_cnt = 0;
    bit rand_timing = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: every accepted byte must match the next expected one.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_overflow) ovf_cnt++;
            if (frame_err) ferr_cnt++;
            if (bus.rx_valid && bus.rx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 32'(bus.rx_data), 32'hffff_ffff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
                    check("rx_parity_err", 32'(bus.rx_parity_err), 32'(e[8]));
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        #1 swim_in = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_times(input logic b, output int lo, output int hi);
        if (rand_timing) begin
            lo = b ? int'($urandom_range(6, 50)) : int'($urandom_range(80, 200));
            hi = b ? int'($urandom_range(10, 150)) : int'($urandom_range(6, 60));
        end else begin
            lo = b ? 12 : 120;
            hi = b ? 120 : 12;
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        int lo, hi;
        bit_times(b, lo, hi);
        hold(1'b0, lo);
        if (glitch) begin
            hold(1'b1, hi / 2);
            hold(1'b0, 2);
            hold(1'b1, hi - hi / 2);
        end else begin
            hold(1'b1, hi);
        end
    endtask

    // glitch_bit selects the frame bit whose high phase gets a 2-cycle low pulse.
    task automatic send_frame(input logic [7:0] d, input logic p, input bit deliver,
                              input bit lat_chk, input int glitch_bit);
        int lo, hi;
        if (deliver) exp_q.push_back({p ^ (^d), d});
        send_bit(1'b0, glitch_bit == 0);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_bit == 8 - i);
        bit_times(p, lo, hi);
        hold(1'b0, lo);
        #1 swim_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (lat_chk) check("valid_before_3rd_edge", 32'(bus.rx_valid), 32'd0);
        @(posedge clk);
        #1;
        if (lat_chk) check("valid_at_3rd_edge", 32'(bus.rx_valid), 32'd1);
        hold(1'b1, 20);
    endtask

    initial begin
        int base;
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(bus.rx_data), 32'h00);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_parity_err", 32'(bus.rx_parity_err), 32'd0);
        check("reset_overflow", 32'(rx_overflow), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        en = 1'b1;
        hold(1'b1, 10);

        // Plain byte, good parity, with completion latency check.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
        // Same byte with bad parity.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1);
        // Glitch inside frame bit 4.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 4);
        check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);
        check("glitch_no_ovf", 32'(ovf_cnt), 32'd0);

        // Overflow: consumer stalled across two frames.
        bus.rx_ready = 1'b0;
        base = ovf_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, -1);
        check("ovf_held_data", 32'(bus.rx_data), 32'h11);
        check("ovf_held_valid", 32'(bus.rx_valid), 32'd1);
        check("ovf_pulses", 32'(ovf_cnt - base), 32'd1);
        #1 bus.rx_ready = 1'b1;
        repeat (5) @(posedge clk);

        // Timeout in a high phase after 4 bits.
        base = ferr_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        hold(1'b1, 1100);
        #1;
        check("timeout_ferr", 32'(ferr_cnt - base), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);

        // Stuck-low abort, then a fresh frame once the line is high again.
        base = ferr_cnt;
        send_bit(1'b0, 1'b0);
        hold(1'b0, 1100);
        #1;
        check("stuck_low_ferr", 32'(ferr_cnt - base), 32'd1);
        check("stuck_low_busy", 32'(busy), 32'd0);
        hold(1'b1, 30);
        check("stuck_low_release_busy", 32'(busy), 32'd0);
        send_frame(8'h69, 1'b1, 1'b1, 1'b0, -1);

        // Reset after 5 bits.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 1'b0);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        hold(1'b1, 10);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, -1);

        // Disabling mid-frame drops it silently.
        base = ferr_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #1 en = 1'b0;
        hold(1'b1, 1100);
        #1;
        check("en_off_busy", 32'(busy), 32'd0);
        check("en_off_no_ferr", 32'(ferr_cnt - base), 32'd0);
        en = 1'b1;
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, -1);

        // Randomized data, parity and bit timing.
        rand_timing = 1'b1;
        for (int n = 0; n < 12; n++) begin
            send_frame(8'($urandom), 1'($urandom), 1'b1, 1'b0, -1);
        end

        repeat (20) @(posedge clk);
        #1;
        check("all_delivered", 32'(exp_q.size()), 32'd0);
        check("xfer_total", 32'(xfer_cnt), 32'd20);
        check("no_stray_ovf", 32'(ovf_cnt), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
